// File: rtl/calc_memoria_banco.sv
// Multi-slot memory bank for the calculator: a command key (save, recall, M+, clear)
// followed by a slot digit stores, returns or accumulates the display value.
module calc_memoria_banco #(
   parameter int         WIDTH      = 16,
   parameter int         SLOTS      = 4,
   parameter int         TIMEOUT    = 1000,
   parameter logic [3:0] COD_SALVAR = 4'b1111,
   parameter logic [3:0] COD_PEGAR0 = 4'b1110,
   parameter logic [3:0] COD_PEGAR1 = 4'b1010,
   parameter logic [3:0] COD_SOMAR  = 4'b1101,
   parameter logic [3:0] COD_LIMPAR = 4'b1100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [3:0]       Escolha,
   input  logic [WIDTH-1:0] valor,
   output logic [WIDTH-1:0] dado_out,
   output logic             Salvar,
   output logic             Pegar,
   output logic             aguardando,
   output logic [SLOTS-1:0] ocupados,
   output logic             ovf
);

   localparam int             CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int             IW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [4:0]     NSLOTS = 5'(SLOTS);
   localparam logic [CW-1:0]  LIMITE = CW'(TIMEOUT - 2);

   typedef enum logic [1:0] {
      OCIOSO,
      ESP_SALVAR,
      ESP_PEGAR,
      ESP_SOMAR
   } estado_t;

   estado_t          estado;
   estado_t          prox;
   logic [WIDTH-1:0] mem [SLOTS];
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic             digito_ok;
   logic             limpar;
   logic [WIDTH:0]   soma;

   assign idx        = Escolha[IW-1:0];
   assign digito_ok  = enable && ({1'b0, Escolha} < NSLOTS);
   assign limpar     = (estado == OCIOSO) && enable && (Escolha == COD_LIMPAR);
   assign soma       = {1'b0, mem[idx]} + {1'b0, valor};
   assign aguardando = (estado != OCIOSO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= OCIOSO;
      else     estado <= prox;
   end

   // Any key while waiting ends the command; the counter bound gives up on a missing digit.
   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO: begin
            if (enable) begin
               case (Escolha)
                  COD_SALVAR:             prox = ESP_SALVAR;
                  COD_PEGAR0, COD_PEGAR1: prox = ESP_PEGAR;
                  COD_SOMAR:              prox = ESP_SOMAR;
                  default:                prox = OCIOSO;
               endcase
            end
         end
         default: begin
            if (enable || (cnt == LIMITE)) prox = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  cnt <= '0;
      else if (estado == OCIOSO) cnt <= '0;
      else if (!enable)         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dado_out <= '0;
         Salvar   <= 1'b0;
         Pegar    <= 1'b0;
         ocupados <= '0;
         ovf      <= 1'b0;
         for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
      end else begin
         Salvar <= 1'b0;
         Pegar  <= 1'b0;
         if (limpar) begin
            ocupados <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
         end else if (digito_ok) begin
            case (estado)
               ESP_SALVAR: begin
                  mem[idx]      <= valor;
                  ocupados[idx] <= 1'b1;
                  Salvar        <= 1'b1;
               end
               ESP_PEGAR: begin
                  dado_out <= mem[idx];
                  Pegar    <= 1'b1;
               end
               ESP_SOMAR: begin
                  mem[idx]      <= soma[WIDTH-1:0];
                  ocupados[idx] <= 1'b1;
                  ovf           <= ovf | soma[WIDTH];
                  Salvar        <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/calc_memoria_banco.md
Name: calc_memoria_banco

Overview:
Parametrised multi-slot memory bank for the calculator. It replaces the single save/recall decode with a sequenced command unit. A command key (save, recall, memory-add, clear) is followed by a digit key that selects one of SLOTS registers. The block stores the current display value, returns stored values, or accumulates into a slot, and sits between the keypad decoder and the display/ALU datapath.

Parameters:
WIDTH, 16, data width of display value and each slot
SLOTS, 4, number of memory slots (1..10, selected by digit keys 0..SLOTS-1)
TIMEOUT, 1000, clock cycles to wait for the slot digit before abandoning the command (>=2)
COD_SALVAR, 4'b1111, key code: save
COD_PEGAR0, 4'b1110, key code: recall (primary)
COD_PEGAR1, 4'b1010, key code: recall (alternate)
COD_SOMAR, 4'b1101, key code: memory-add (M+)
COD_LIMPAR, 4'b1100, key code: clear all slots

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  key strobe, one cycle per key press
Escolha  input  4  key code, valid when enable=1
valor  input  WIDTH  current display value, sampled on the slot-digit cycle
dado_out  output  WIDTH  last recalled slot value, held until next recall
Salvar  output  1  one-cycle pulse: save or M+ completed
Pegar  output  1  one-cycle pulse: recall completed, dado_out updated same cycle
aguardando  output  1  high while waiting for slot digit
ocupados  output  SLOTS  bit s set once slot s has been written since last clear
ovf  output  1  sticky: an M+ carried out of WIDTH bits

Behaviour:
- One clock and an asynchronous active-high reset, as already decided. Clock port is clk, reset port is rst.
- Reset: state OCIOSO; all slots 0; dado_out=0; Salvar=Pegar=0; aguardando=0; ocupados=0; ovf=0; timeout counter=0. Reset mid-sequence abandons the pending command with no write.
- Digit keys are 4'd0..4'd9. Command codes are >=10, so the two sets are disjoint. Keys 11 (4'b1011) and other undefined codes are ignored in OCIOSO.
- FSM states: OCIOSO, ESP_SALVAR, ESP_PEGAR, ESP_SOMAR.
- OCIOSO + enable:
  - COD_SALVAR -> ESP_SALVAR.
  - COD_PEGAR0 or COD_PEGAR1 -> ESP_PEGAR.
  - COD_SOMAR -> ESP_SOMAR.
  - COD_LIMPAR -> all slots=0, ocupados=0, ovf=0 at next edge; stay OCIOSO; no pulse.
  - Digits are ignored.
- aguardando=1 exactly while in any ESP_ state (registered state decode).
- ESP_x + enable with Escolha < SLOTS (slot s):
  - Action commits at that edge; state returns to OCIOSO.
  - Salvar/Pegar are registered and high the cycle after the digit key.
- ESP_SALVAR: mem[s] <= valor; ocupados[s] <= 1; Salvar pulse.
- ESP_PEGAR: dado_out <= mem[s]; Pegar pulse. An empty slot returns 0 and still pulses.
- ESP_SOMAR:
  - mem[s] <= (mem[s] + valor) mod 2^WIDTH, unsigned.
  - ovf <= 1 if the carry-out is set (never cleared except by COD_LIMPAR or reset).
  - ocupados[s] <= 1; Salvar pulse.
- ESP_x + enable with digit >= SLOTS or any command code: abort to OCIOSO, no write, no pulse. The command key is not re-interpreted; a fresh press is needed.
- Timeout: counter clears on entering ESP_x and increments each cycle without enable. On reaching TIMEOUT-1 the block returns to OCIOSO with no action.
- enable=0: no state change except the timeout count.
- Latency: command key -> aguardando 1 cycle; digit key -> memory/dado_out update 1 cycle, pulse in the same cycle as the update.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately. Repeat during ESP_SALVAR, then press digit 0 -> mem[0] unchanged (recall slot 0 gives 0).
- Save/recall: valor=16'h1234, keys 1111 then 2 -> Salvar pulse, ocupados=4'b0100. Then 1010 then 2 -> Pegar pulse, dado_out=16'h1234.
- M+ overflow: slot1=16'hFFF0, valor=16'h0020, keys 1101 then 1 -> slot1=16'h0010, ovf=1. Then 1100 -> ovf=0, ocupados=0, recall slot1 gives 0.
- Abort: with SLOTS=4, keys 1111 then 7 -> no Salvar, aguardando falls. Keys 1110 then 1111 -> OCIOSO, next digit ignored.
- Timeout (TIMEOUT=8): key 1111, idle 7 cycles -> aguardando=0. Digit 0 afterwards -> no write.
- Parametrisation: WIDTH=8, SLOTS=10. Save 8'hA5 into slot 9, recall via 1110 -> dado_out=8'hA5, ocupados[9]=1.
